// File: rtl/muxn_scan_pkg.sv
// Shared types and constants for the scanning N:1 multiplexer.
package mux_pkg;

    typedef enum logic {S_IDLE, S_SCAN} scan_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : mux_pkg

// File: rtl/muxn_scan_if.sv
// Channel/control bundle between the operand sources, the controller and muxn_scan.
interface muxn_scan_if #(
    parameter int W    = 8,
    parameter int N    = 5,
    parameter int SELW = (N == 1) ? 1 : $clog2(N)
);
    logic [N*W-1:0]  d;
    logic [SELW-1:0] s;
    logic            mode;
    logic            start;
    logic            hold;
    logic [W-1:0]    y;
    logic            y_valid;
    logic [SELW-1:0] sel_cur;
    logic            done;
    logic            busy;

    // Controller side: drives channels and control, observes the registered result.
    modport master (
        output d, s, mode, start, hold,
        input  y, y_valid, sel_cur, done, busy
    );

    // Multiplexer side.
    modport slave (
        input  d, s, mode, start, hold,
        output y, y_valid, sel_cur, done, busy
    );
endinterface : muxn_scan_if

// File: rtl/muxn_scan_muxn.sv
// Combinational N:1 multiplexer; out-of-range selects give all-zero, never X.
module muxn #(
    parameter int W    = 8,
    parameter int N    = 5,
    parameter int SELW = (N == 1) ? 1 : $clog2(N)
) (
    input  logic [N*W-1:0]  d,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    y
);

    // Pick the channel whose index equals sel; no match leaves the zero default.
    always_comb begin
        // NOTE: default first so every path assigns y and no latch is inferred.
        y = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                y = d[k*W +: W];
            end
        end
    end

endmodule : muxn

// File: rtl/muxn_scan.sv
// Registered N:1 multiplexer with direct-select and scan-all-channels modes.
module muxn_scan
    import mux_pkg::*;
#(
    parameter int W    = 8,
    parameter int N    = 5,
    parameter int SELW = (N == 1) ? 1 : $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    muxn_scan_if.slave   bus
);

    scan_state_t     state;
    logic [SELW-1:0] cnt;
    logic [SELW-1:0] mux_sel;
    logic [W-1:0]    mux_y;

    // Mux select: direct select in IDLE/direct and on abort, 0 on the start edge, cnt while scanning.
    always_comb begin
        mux_sel = '0;
        if (bus.mode == MODE_DIRECT) begin
            mux_sel = bus.s;
        end else if (state == S_SCAN) begin
            mux_sel = cnt;
        end
    end

    muxn #(
        .W    (W),
        .N    (N),
        .SELW (SELW)
    ) u_muxn (
        .d   (bus.d),
        .sel (mux_sel),
        .y   (mux_y)
    );

    // Scan FSM, counter and registered outputs; reset is synchronous.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bus.y       <= '0;
            bus.y_valid <= 1'b0;
            bus.sel_cur <= '0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.mode == MODE_DIRECT) begin
                        bus.y       <= mux_y;
                        bus.sel_cur <= bus.s;
                        bus.y_valid <= 1'b1;
                    end else if (bus.start) begin
                        bus.y       <= mux_y;
                        bus.sel_cur <= '0;
                        bus.y_valid <= 1'b1;
                        if (N == 1) begin
                            bus.done <= 1'b1;
                        end else begin
                            cnt   <= SELW'(1);
                            state <= S_SCAN;
                        end
                    end else begin
                        bus.y_valid <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (bus.mode == MODE_DIRECT) begin
                        // Abort: leave the scan silently and perform the direct load.
                        state       <= S_IDLE;
                        cnt         <= '0;
                        bus.y       <= mux_y;
                        bus.sel_cur <= bus.s;
                        bus.y_valid <= 1'b1;
                    end else if (bus.hold) begin
                        bus.y_valid <= 1'b0;
                    end else begin
                        bus.y       <= mux_y;
                        bus.sel_cur <= cnt;
                        bus.y_valid <= 1'b1;
                        if (cnt == SELW'(N - 1)) begin
                            bus.done <= 1'b1;
                            cnt      <= '0;
                            state    <= S_IDLE;
                        end else begin
                            cnt <= cnt + SELW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (state == S_SCAN);

endmodule : muxn_scan

// File: doc/muxn_scan.md
Name: muxn_scan

Overview:
- Parametrised, registered N:1 multiplexer of W-bit channels; the next generation of the 5:1 select switch used in the multiplier datapath.
- Two modes:
  - Direct: registered select, 1-cycle latency.
  - Scan: an internal counter steps through all channels once, with hold/stall and a done pulse.
- Sits between operand/partial-product sources and the multiplier controller, so the controller can either pick a channel or sequence through all of them.

Parameters:
W, 8, data width of each channel and of y
N, 5, number of channels (N >= 1)
SELW, $clog2(N) (1 when N==1), width of select/count fields

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
d  in  N*W  flattened channel data; channel k at d[k*W +: W]
s  in  SELW  direct-mode select
mode  in  1  0 = direct, 1 = scan
start  in  1  begin a scan (honoured in IDLE with mode=1 only)
hold  in  1  stall scan (counter and y frozen)
y  out  W  registered selected data
y_valid  out  1  y was loaded at the last edge
sel_cur  out  SELW  channel index currently held in y
done  out  1  one-cycle pulse: last scan element is in y
busy  out  1  state == SCAN

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset (any state, including mid-scan):
  - y=0, y_valid=0, sel_cur=0, done=0, busy=0.
  - State IDLE, cnt=0.
- Select function sel(i): d[i] if i < N, else all-zero. No X propagation for out-of-range i.
- d is sampled live at each loading edge, with no snapshot. Stability during a scan is the caller's responsibility.
- States are IDLE and SCAN. In every state, done defaults to 0 unless set by the SCAN rules.
- IDLE, mode=0 (direct), every edge:
  - y<=sel(s), sel_cur<=s, y_valid<=1.
  - Latency is 1 cycle. hold and start are ignored.
- IDLE, mode=1, start=0:
  - y and sel_cur keep their values; y_valid<=0.
- IDLE, mode=1, start=1:
  - y<=d[0], sel_cur<=0, y_valid<=1.
  - If N==1: done<=1 and stay in IDLE.
  - Else: cnt<=1, go to SCAN.
  - hold is ignored on the start edge.
- SCAN, hold=0:
  - y<=d[cnt], sel_cur<=cnt, y_valid<=1.
  - If cnt==N-1: done<=1, cnt<=0, go to IDLE.
  - Else: cnt<=cnt+1.
- SCAN, hold=1:
  - y, sel_cur and cnt unchanged; y_valid<=0, done<=0.
- SCAN, mode=0 (abort):
  - Abort has priority over hold and start.
  - Go to IDLE, cnt<=0, no done pulse.
  - The same edge performs the direct load: y<=sel(s), sel_cur<=s, y_valid<=1.
- start in SCAN is ignored; it never restarts the counter.
- Scan timing: start sampled at edge E0 gives y=d[k] after edge Ek (no holds). done is high in the cycle after E(N-1), together with y=d[N-1]. Total N cycles.
- Back-to-back scans: start may be high in the cycle done is high. The next scan loads d[0] on that edge, with no gap cycle.
- cnt never exceeds N-1. sel_cur in scan mode is always < N.

Decomposition:
- Shared package mux_pkg:
  - typedef enum logic {S_IDLE, S_SCAN} scan_state_t;
  - localparam MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
- Sub-module muxn: combinational, parametrised W/N/SELW N:1 mux with zero output for out-of-range select; the generalised 5:1 switch.
  - muxn_scan instantiates one muxn.
  - Its select is driven by s in IDLE/direct, 0 on the start edge, and cnt in SCAN.
  - All registers, the FSM and the counter live in muxn_scan.

Test Plan:
(W=8, N=5, d0..d4 = 0x11,0x22,0x33,0x44,0x55 unless stated)
1. Hold reset 2 cycles, release with mode=1, start=0 -> y=0x00, y_valid=0, sel_cur=0, done=0, busy=0.
2. Direct mode: s=3 -> one edge later y=0x44, y_valid=1, sel_cur=3. Then s=6 -> y=0x00, sel_cur=6. Then s=0 -> y=0x11.
3. Scan: mode=1, start=1 for one cycle -> y=0x11,0x22,0x33,0x44,0x55 on 5 consecutive cycles, y_valid=1 each. done=1 only with 0x55. busy falls with done. Start held during done -> next cycle y=0x11 again.
4. Hold: scan with hold=1 for 2 cycles after y=0x22 -> y stays 0x22, y_valid=0, sel_cur=1 for those 2 cycles. Then 0x33,0x44,0x55; done after 7 cycles total.
5. Abort and ignore:
   - start pulsed again while y=0x33 -> sequence unaffected.
   - Separate scan: mode->0 with s=4 while y=0x22 -> next y=0x55, sel_cur=4, busy=0, no done pulse ever.
6. Reset mid-scan (y=0x33) -> next cycle all outputs at reset values. A new start then yields 0x11 first.
   - Repeat with N=1 (d0=0xA5): start -> y=0xA5 with done=1 on the same edge, busy never 1.
